// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: link FSM state encoding and frame geometry.
// Used by the host transmitter and the device-to-host receivers.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SEND,
    ACK,
    WAITIDLE
  } state_t;

  localparam int FRAME_BITS = 10;
  localparam int ACK_FALL   = 11;

  function automatic logic odd_par(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 line conditioner: 2-FF synchronizer, run-length glitch filter
// and a one-cycle pulse on each accepted high-to-low transition.
module ps2_line_filter #(
  parameter int FILT_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic fall
);

  localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          s;
  logic          hit;

  assign s   = sync[1];
  assign hit = (cnt == CW'(FILT_LEN - 1));

  // New level is taken only after FILT_LEN samples disagree in a row
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync  <= 2'b11;
      level <= 1'b1;
      fall  <= 1'b0;
      cnt   <= '0;
    end else begin
      sync <= {sync[0], raw};
      fall <= 1'b0;
      if (s == level) begin
        cnt <= '0;
      end else if (hit) begin
        level <= s;
        fall  <= level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: sends one command byte over the
// open-drain clock/data pair and checks the device acknowledge.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYC  = 2500,
  parameter int EDGE_TMO_CYC = 375000,
  parameter int FILT_LEN     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       rdy,
  output logic       done,
  output logic       err,
  output logic       rx_inh,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe
);

  localparam int TMAX = (INHIBIT_CYC > EDGE_TMO_CYC) ?
                        INHIBIT_CYC : EDGE_TMO_CYC;
  localparam int CW = $clog2(TMAX + 1);

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [3:0]            bitcnt;
  logic [FRAME_BITS-1:0] frame;
  logic                  clk_lvl;
  logic                  clk_fall;
  logic                  dat_lvl;
  logic                  dat_fall_unused;
  logic                  inh_end;
  logic                  tmo;
  logic                  active;
  logic                  abort;

  ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_clk_filt (
    .clk  (clk),
    .rst  (rst),
    .raw  (ps2c_in),
    .level(clk_lvl),
    .fall (clk_fall)
  );

  ps2_line_filter #(.FILT_LEN(1)) u_dat_filt (
    .clk  (clk),
    .rst  (rst),
    .raw  (ps2d_in),
    .level(dat_lvl),
    .fall (dat_fall_unused)
  );

  assign inh_end = (cnt == CW'(INHIBIT_CYC - 1));
  assign tmo     = (cnt == CW'(EDGE_TMO_CYC - 1));
  assign active  = (state == SEND) || (state == ACK) ||
                   (state == WAITIDLE);
  // A device edge in the terminal cycle still counts as progress
  assign abort   = active && tmo && !clk_fall;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bitcnt  <= '0;
      frame   <= '0;
      rdy     <= 1'b1;
      done    <= 1'b0;
      err     <= 1'b0;
      rx_inh  <= 1'b0;
      ps2c_oe <= 1'b0;
      ps2d_oe <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state   <= IDLE;
        cnt     <= '0;
        err     <= 1'b1;
        done    <= 1'b1;
        rdy     <= 1'b1;
        rx_inh  <= 1'b0;
        ps2c_oe <= 1'b0;
        ps2d_oe <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              frame   <= {1'b1, odd_par(data), data};
              err     <= 1'b0;
              cnt     <= '0;
              rdy     <= 1'b0;
              rx_inh  <= 1'b1;
              ps2c_oe <= 1'b1;
              state   <= INHIBIT;
            end
          end
          INHIBIT: begin
            if (inh_end) begin
              cnt     <= '0;
              ps2d_oe <= 1'b1;
              state   <= REQ;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          REQ: begin
            ps2c_oe <= 1'b0;
            cnt     <= '0;
            bitcnt  <= '0;
            state   <= SEND;
          end
          SEND: begin
            if (clk_fall) begin
              ps2d_oe <= ~frame[bitcnt];
              bitcnt  <= bitcnt + 1'b1;
              cnt     <= '0;
              if (bitcnt == 4'(FRAME_BITS - 1))
                state <= ACK;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ACK: begin
            if (clk_fall && bitcnt == 4'(ACK_FALL - 1)) begin
              err    <= dat_lvl;
              bitcnt <= bitcnt + 1'b1;
              cnt    <= '0;
              state  <= WAITIDLE;
            end else if (clk_fall) begin
              cnt <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          WAITIDLE: begin
            if (clk_lvl && dat_lvl) begin
              done   <= 1'b1;
              rdy    <= 1'b1;
              rx_inh <= 1'b0;
              cnt    <= '0;
              state  <= IDLE;
            end else if (clk_fall) begin
              cnt <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: behavioural PS/2 device on an open-drain bus,
// per-cycle rule checks and directed frame tests.
module tb_ps2_host_tx;

  localparam int I = 50;
  localparam int E = 400;
  localparam int F = 4;
  localparam int H = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] data = 8'h00;
  logic       rdy, done, err, rx_inh, ps2c_oe, ps2d_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  wire        ps2c_line = !(ps2c_oe || dev_clk_low);
  wire        ps2d_line = !(ps2d_oe || dev_dat_low);

  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0;
  logic cmp_en = 1'b0;
  logic prev_done = 1'b0;
  logic cap_start, cap_par, cap_stop;
  logic [7:0] cap_byte;

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYC (I),
    .EDGE_TMO_CYC(E),
    .FILT_LEN    (F)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .data   (data),
    .rdy    (rdy),
    .done   (done),
    .err    (err),
    .rx_inh (rx_inh),
    .ps2c_in(ps2c_line),
    .ps2d_in(ps2d_line),
    .ps2c_oe(ps2c_oe),
    .ps2d_oe(ps2d_oe)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Odd parity from a population count
  function automatic logic model_par(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return (ones % 2) == 0;
  endfunction

  always @(posedge clk) if (done) done_cnt++;

  always @(negedge clk) begin
    if (cmp_en && rst) begin
      chk("rx_inh_vs_rdy", {31'b0, rx_inh}, {31'b0, !rdy});
      if (rdy) begin
        chk("idle_c_released", {31'b0, ps2c_oe}, 32'd0);
        chk("idle_d_released", {31'b0, ps2d_oe}, 32'd0);
      end
      if (done) chk("done_with_rdy", {31'b0, rdy}, 32'd1);
      chk("done_one_cycle", {31'b0, done && prev_done}, 32'd0);
      prev_done = done;
    end
  end

  task automatic pulse_start(input logic [7:0] d);
    @(negedge clk);
    data  = d;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic dev(input int nfall, input bit ack, input bit glitch,
                     output bit ok);
    int n;
    n  = 0;
    ok = 1'b0;
    while (!(ps2c_line && !ps2d_line) && n < I + 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= I + 200) begin
      chk("request_seen", 32'd0, 32'd1);
      return;
    end
    cap_start = ps2d_line;
    repeat (H) @(negedge clk);
    for (int k = 1; k <= nfall; k++) begin
      dev_clk_low = 1'b1;
      repeat (H) @(negedge clk);
      if (k <= 8) cap_byte[k-1] = ps2d_line;
      else if (k == 9) cap_par = ps2d_line;
      else if (k == 10) cap_stop = ps2d_line;
      dev_clk_low = 1'b0;
      if (k == 10 && ack) dev_dat_low = 1'b1;
      if (k == 11) dev_dat_low = 1'b0;
      for (int j = 0; j < H; j++) begin
        @(negedge clk);
        if (glitch && j == H / 2) dev_clk_low = 1'b1;
        else if (glitch && j == H / 2 + 1) dev_clk_low = 1'b0;
      end
    end
    ok = 1'b1;
  endtask

  task automatic wait_done(input int base, input string tag);
    int n;
    n = 0;
    while (done_cnt == base && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    chk({tag, "_done_count"}, done_cnt, base + 1);
  endtask

  task automatic xfer(input logic [7:0] d, input bit ack, input bit glitch,
                      input string tag);
    int base;
    bit ok;
    base      = done_cnt;
    cap_byte  = 'x;
    cap_start = 'x;
    cap_par   = 'x;
    cap_stop  = 'x;
    pulse_start(d);
    chk({tag, "_c_oe_latency"}, {31'b0, ps2c_oe}, 32'd1);
    chk({tag, "_busy"}, {31'b0, rdy}, 32'd0);
    dev(11, ack, glitch, ok);
    wait_done(base, tag);
    chk({tag, "_start_bit"}, {31'b0, cap_start}, 32'd0);
    chk({tag, "_byte"}, {24'b0, cap_byte}, {24'b0, d});
    chk({tag, "_parity"}, {31'b0, cap_par}, {31'b0, model_par(d)});
    chk({tag, "_stop_bit"}, {31'b0, cap_stop}, 32'd1);
    chk({tag, "_err"}, {31'b0, err}, {31'b0, !ack});
    chk({tag, "_rdy"}, {31'b0, rdy}, 32'd1);
    chk({tag, "_lines"}, {30'b0, ps2c_oe, ps2d_oe}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    bit ok;

    repeat (3) @(negedge clk);
    chk("rst_rdy", {31'b0, rdy}, 32'd1);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_rx_inh", {31'b0, rx_inh}, 32'd0);
    chk("rst_lines", {30'b0, ps2c_oe, ps2d_oe}, 32'd0);
    rst    = 1'b1;
    cmp_en = 1'b1;
    repeat (3) @(negedge clk);

    xfer(8'hF4, 1'b1, 1'b0, "f4");
    chk("f4_parity_lit", {31'b0, cap_par}, 32'd0);
    chk("f4_byte_lit", {24'b0, cap_byte}, 32'h0000_00F4);

    xfer(8'h00, 1'b1, 1'b0, "x00");
    chk("x00_parity_lit", {31'b0, cap_par}, 32'd1);
    xfer(8'hFF, 1'b1, 1'b1, "xff_glitch");
    chk("xff_parity_lit", {31'b0, cap_par}, 32'd1);

    xfer(8'hA5, 1'b0, 1'b0, "noack");

    base = done_cnt;
    pulse_start(8'h3C);
    n = 0;
    while (!done && n < I + E + 50) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_in_window", {31'b0, (n >= I + E - 2) && (n <= I + E + 2)},
        32'd1);
    chk("tmo_err", {31'b0, err}, 32'd1);
    chk("tmo_lines", {30'b0, ps2c_oe, ps2d_oe}, 32'd0);
    repeat (3) @(negedge clk);
    chk("tmo_done_count", done_cnt, base + 1);
    chk("tmo_rdy", {31'b0, rdy}, 32'd1);

    base     = done_cnt;
    cap_byte = 'x;
    pulse_start(8'h3A);
    fork
      dev(11, 1'b1, 1'b0, ok);
      begin
        repeat (I + 120) @(negedge clk);
        pulse_start(8'h55);
      end
    join
    wait_done(base, "busy_start");
    chk("busy_start_byte", {24'b0, cap_byte}, 32'h0000_003A);
    chk("busy_start_err", {31'b0, err}, 32'd0);
    repeat (I + 40) @(negedge clk);
    chk("busy_start_no_queue", done_cnt, base + 1);
    chk("busy_start_idle_c", {31'b0, ps2c_oe}, 32'd0);

    base = done_cnt;
    pulse_start(8'hAA);
    dev(5, 1'b0, 1'b0, ok);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("midrst_lines", {30'b0, ps2c_oe, ps2d_oe}, 32'd0);
    chk("midrst_rdy", {31'b0, rdy}, 32'd1);
    chk("midrst_rx_inh", {31'b0, rx_inh}, 32'd0);
    repeat (5) @(negedge clk);
    chk("midrst_no_done", done_cnt, base);
    xfer(8'hED, 1'b1, 1'b0, "ed_after_rst");

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, failures);
    $finish;
  end

endmodule
